// File: rtl/seq_player.sv
// rtl/seq_player.sv - LFSR-generated colour sequence store and timed playback engine
//
// Ports:
//   clock    - single rising-edge clock
//   reset    - synchronous active-high reset (sequence memory is not cleared)
//   gerar    - one-cycle request to regenerate the sequence from semente
//   semente  - 16-bit LFSR seed (0x0000 is replaced by 0x0001)
//   start    - one-cycle request to play the first nivel steps
//   nivel    - number of steps to play, clamped to 1..2^PROF
//   address  - lookup index for esperado
//   esperado - registered one-hot colour of mem[address], one-cycle latency
//   saida    - one-hot colour being displayed, all-zero when dark
//   passo    - index of the step currently being played
//   busy     - high whenever the FSM is not idle
//   pronto   - high once a complete sequence has been generated
//   done     - one-cycle pulse when playback ends
//
// Optional feature: define SEQ_SPEEDUP_EN to halve the on-time for long sequences.

module seq_player #(
    parameter int N_CORES = 4,
    parameter int PROF    = 4,
    parameter int T_ON    = 8,
    parameter int T_OFF   = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               gerar,
    input  logic [15:0]        semente,
    input  logic               start,
    input  logic [PROF:0]      nivel,
    input  logic [PROF-1:0]    address,
    output logic [N_CORES-1:0] esperado,
    output logic [N_CORES-1:0] saida,
    output logic [PROF-1:0]    passo,
    output logic               busy,
    output logic               pronto,
    output logic               done
);

    localparam int CW      = $clog2(N_CORES);
    localparam int DEPTH   = 1 << PROF;
    localparam int LW      = PROF + 1;
    localparam int TW      = 16;
    localparam int ON_FAST = ((T_ON / 2) > 1) ? (T_ON / 2) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GEN,
        S_ON,
        S_OFF,
        S_FIM
    } state_t;

    state_t              state_q, state_d;
    logic [15:0]         lfsr_q, lfsr_d;
    logic [PROF-1:0]     gen_idx_q, gen_idx_d;
    logic [PROF-1:0]     passo_q, passo_d;
    logic [LW-1:0]       len_q, len_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [N_CORES-1:0]  saida_q, saida_d;
    logic [N_CORES-1:0]  esperado_q, esperado_d;
    logic                busy_q, busy_d;
    logic                pronto_q, pronto_d;
    logic                done_q, done_d;

    logic [CW-1:0]       mem_q [DEPTH];
    logic                mem_we;
    logic [CW-1:0]       mem_wdata;

    logic                lfsr_fb;
    logic [15:0]         lfsr_step;
    logic [TW-1:0]       on_cycles;
    logic                last_step;
    logic [LW-1:0]       nivel_clamped;

    function automatic logic [N_CORES-1:0] onehot(input logic [CW-1:0] idx);
        logic [N_CORES-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    assign lfsr_fb   = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign lfsr_step = {lfsr_q[14:0], lfsr_fb};

    // len_q is only consulted while playing, after it has been latched
`ifdef SEQ_SPEEDUP_EN
    assign on_cycles = (len_q > LW'(DEPTH / 2)) ? TW'(ON_FAST) : TW'(T_ON);
`else
    assign on_cycles = TW'(T_ON);
`endif

    assign last_step = ({1'b0, passo_q} == (len_q - LW'(1)));

    always_comb begin
        nivel_clamped = nivel;
        if (nivel == '0) begin
            nivel_clamped = LW'(1);
        end else if (nivel > LW'(DEPTH)) begin
            nivel_clamped = LW'(DEPTH);
        end
    end

    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        gen_idx_d  = gen_idx_q;
        passo_d    = passo_q;
        len_d      = len_q;
        timer_d    = timer_q;
        pronto_d   = pronto_q;
        mem_we     = 1'b0;
        mem_wdata  = lfsr_q[CW-1:0];

        case (state_q)
            S_IDLE: begin
                // gerar has priority over a simultaneous start
                if (gerar) begin
                    state_d   = S_GEN;
                    lfsr_d    = (semente == 16'h0000) ? 16'h0001 : semente;
                    gen_idx_d = '0;
                end else if (start && pronto_q) begin
                    state_d = S_ON;
                    len_d   = nivel_clamped;
                    passo_d = '0;
                    timer_d = '0;
                end
            end
            S_GEN: begin
                mem_we    = 1'b1;
                lfsr_d    = lfsr_step;
                gen_idx_d = gen_idx_q + PROF'(1);
                if (gen_idx_q == PROF'(DEPTH - 1)) begin
                    pronto_d = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            S_ON: begin
                if (timer_q == on_cycles - TW'(1)) begin
                    state_d = S_OFF;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_OFF: begin
                if (timer_q == TW'(T_OFF - 1)) begin
                    timer_d = '0;
                    if (last_step) begin
                        state_d = S_FIM;
                    end else begin
                        passo_d = passo_q + PROF'(1);
                        state_d = S_ON;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_FIM: begin
                state_d = S_IDLE;
                passo_d = '0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with it
        saida_d    = (state_d == S_ON) ? onehot(mem_q[passo_d]) : '0;
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_FIM);
        esperado_d = onehot(mem_q[address]);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            lfsr_q     <= 16'h0001;
            gen_idx_q  <= '0;
            passo_q    <= '0;
            len_q      <= LW'(1);
            timer_q    <= '0;
            saida_q    <= '0;
            esperado_q <= '0;
            busy_q     <= 1'b0;
            pronto_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            gen_idx_q  <= gen_idx_d;
            passo_q    <= passo_d;
            len_q      <= len_d;
            timer_q    <= timer_d;
            saida_q    <= saida_d;
            esperado_q <= esperado_d;
            busy_q     <= busy_d;
            pronto_q   <= pronto_d;
            done_q     <= done_d;
            // Memory contents deliberately survive reset
            if (mem_we) begin
                mem_q[gen_idx_q] <= mem_wdata;
            end
        end
    end

    assign esperado = esperado_q;
    assign saida    = saida_q;
    assign passo    = passo_q;
    assign busy     = busy_q;
    assign pronto   = pronto_q;
    assign done     = done_q;

endmodule
